pad_output_ctrl: RTL and testbench

// - Drive-side controller for one bidirectional/output pad cell; the transmit counterpart of the input pad path.
// - Accepts drive/release requests over a valid/ready handshake and produces registered pad_out_o/pad_oe_o for the pad cell.
// - Enforces break-before-make: after release, a fixed turnaround window of TURN_CYCLES cycles elapses before re-drive.
// - Sits between peripheral/pad-control logic and the pad ring, next to the pad cell instance.

---
 rtl/pad_output_ctrl.sv | 98 +++++++++
 tb/tb_pad_output_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pad_output_ctrl.sv
// pad_output_ctrl: registered drive/release controller for one pad cell with break-before-make turnaround; `PAD_OUT_READBACK_EN adds a sticky readback-conflict checker
module pad_output_ctrl #(
  parameter int PADATTR = 16,
  parameter int TURN_CYCLES = 2,
  localparam int PADATTR_RND = (PADATTR == 0) ? 1 : PADATTR
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_oe_i,
  input  logic                   req_data_i,
  input  logic [PADATTR_RND-1:0] req_attr_i,
  output logic                   pad_out_o,
  output logic                   pad_oe_o,
  output logic [PADATTR_RND-1:0] pad_attributes_o,
  input  logic                   pad_sense_i,
  output logic                   busy_o,
  output logic                   conflict_o,
  input  logic                   conflict_clr_i
);
  localparam int CW = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;
  typedef enum logic [1:0] {HIZ, DRIVE, TURN} state_t;
  state_t state_q, state_d;
  logic pad_out_q, pad_out_d, pad_oe_q, pad_oe_d;
  logic [PADATTR_RND-1:0] attr_q, attr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    pad_out_d = pad_out_q;
    pad_oe_d = pad_oe_q;
    attr_d = attr_q;
    cnt_d = cnt_q;
    if (state_q == TURN) begin
      cnt_d = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
      state_d = (cnt_q <= CW'(1)) ? HIZ : TURN;
    end else if (req_valid_i) begin
      attr_d = req_attr_i;
      if (req_oe_i) begin
        pad_out_d = req_data_i;
        pad_oe_d = 1'b1;
        state_d = DRIVE;
      end else if (state_q == DRIVE) begin
        pad_oe_d = 1'b0;
        cnt_d = CW'(TURN_CYCLES);
        state_d = (TURN_CYCLES == 0) ? HIZ : TURN;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= HIZ;
      pad_out_q <= 1'b0;
      pad_oe_q <= 1'b0;
      attr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pad_out_q <= pad_out_d;
      pad_oe_q <= pad_oe_d;
      attr_q <= attr_d;
      cnt_q <= cnt_d;
    end
  end
  assign req_ready_o = (state_q != TURN);
  assign busy_o = (state_q == TURN);
  assign pad_out_o = pad_out_q;
  assign pad_oe_o = pad_oe_q;
  assign pad_attributes_o = attr_q;
`ifdef PAD_OUT_READBACK_EN
  // stable_q: pad_out_o has been held in DRIVE for at least one full cycle, so the pad has settled
  logic stable_q, stable_d, conflict_q, conflict_d, mismatch;
  always_comb begin
    mismatch = (state_q == DRIVE) && stable_q && (pad_sense_i != pad_out_q);
    stable_d = (state_q == DRIVE) && (state_d == DRIVE) && (pad_out_d == pad_out_q);
    conflict_d = mismatch | (conflict_q & ~conflict_clr_i);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stable_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      stable_q <= stable_d;
      conflict_q <= conflict_d;
    end
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i && mismatch) $error("pad readback mismatch at %0t: out=%b sense=%b", $time, pad_out_q, pad_sense_i);
  end
`endif
  assign conflict_o = conflict_q;
`else
  logic unused_readback;
  assign unused_readback = pad_sense_i ^ conflict_clr_i;
  assign conflict_o = 1'b0;
`endif
endmodule

// File: tb/tb_pad_output_ctrl.sv
// tb_pad_output_ctrl: directed and randomized checks of pad_output_ctrl (TURN_CYCLES=2 and 0 instances) against a queue-free turnaround model
module tb_pad_output_ctrl;
  logic clk = 0, rst = 1, valid = 0, oe = 0, data = 0, sense = 0, clr = 0;
  logic [15:0] attr = '0;
  logic rdy, pout, poe, busy, conf, rdy0, pout0, poe0, busy0, conf0;
  logic [15:0] pattr, pattr0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  pad_output_ctrl #(.PADATTR(16), .TURN_CYCLES(2)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(rdy), .req_oe_i(oe), .req_data_i(data),
    .req_attr_i(attr), .pad_out_o(pout), .pad_oe_o(poe), .pad_attributes_o(pattr), .pad_sense_i(sense),
    .busy_o(busy), .conflict_o(conf), .conflict_clr_i(clr));
  pad_output_ctrl #(.PADATTR(16), .TURN_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(rdy0), .req_oe_i(oe), .req_data_i(data),
    .req_attr_i(attr), .pad_out_o(pout0), .pad_oe_o(poe0), .pad_attributes_o(pattr0), .pad_sense_i(sense),
    .busy_o(busy0), .conflict_o(conf0), .conflict_clr_i(clr));
  // reference: a pad either drives or not; a release from driving blocks new requests for TURN cycles
  int m_left = 0, m_left0 = 0;
  logic m_out = 0, m_oe = 0, m_out0 = 0, m_oe0 = 0;
  logic [15:0] m_attr = '0, m_attr0 = '0;
  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0; m_out <= 0; m_oe <= 0; m_attr <= '0;
    end else if (m_left > 0) m_left <= m_left - 1;
    else if (valid) begin
      m_attr <= attr;
      if (oe) begin m_out <= data; m_oe <= 1; end
      else if (m_oe) begin m_oe <= 0; m_left <= 2; end
    end
  end
  always @(posedge clk) begin
    if (rst) begin
      m_left0 <= 0; m_out0 <= 0; m_oe0 <= 0; m_attr0 <= '0;
    end else if (m_left0 > 0) m_left0 <= m_left0 - 1;
    else if (valid) begin
      m_attr0 <= attr;
      if (oe) begin m_out0 <= data; m_oe0 <= 1; end
      else if (m_oe0) begin m_oe0 <= 0; m_left0 <= 0; end
    end
  end
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1; valid = 0;
    tick(); tick();
    rst = 0;
    checks++; if (poe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", poe); end
    checks++; if (pout !== 1'b0) begin failures++; $display("FAIL reset_out got=%b exp=0", pout); end
    checks++; if (pattr !== 16'h0) begin failures++; $display("FAIL reset_attr got=%h exp=0000", pattr); end
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", rdy); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (conf !== 1'b0) begin failures++; $display("FAIL reset_conflict got=%b exp=0", conf); end
  endtask
  task automatic test_drive_stream();
    logic [2:0] seq;
    seq = 3'b010;
    valid = 1; oe = 1; data = 1; attr = 16'h00A5;
    tick();
    checks++; if (poe !== 1'b1) begin failures++; $display("FAIL drive_oe got=%b exp=1", poe); end
    checks++; if (pout !== 1'b1) begin failures++; $display("FAIL drive_out got=%b exp=1", pout); end
    checks++; if (pattr !== 16'h00A5) begin failures++; $display("FAIL drive_attr got=%h exp=00a5", pattr); end
    for (int i = 2; i >= 0; i--) begin
      data = seq[i];
      tick();
      checks++; if (pout !== seq[i]) begin failures++; $display("FAIL stream_out[%0d] got=%b exp=%b", i, pout, seq[i]); end
      checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, rdy); end
    end
  endtask
  task automatic test_back_to_back_release();
    valid = 1; oe = 0;
    tick();
    checks++; if (poe !== 1'b0) begin failures++; $display("FAIL rel_oe got=%b exp=0", poe); end
    checks++; if (pout !== 1'b0) begin failures++; $display("FAIL rel_out_held got=%b exp=0", pout); end
    oe = 1; data = 1;
    for (int i = 0; i < 2; i++) begin
      checks++; if ({rdy, busy} !== 2'b01) begin failures++; $display("FAIL turn_stall[%0d] ready/busy got=%b%b exp=01", i, rdy, busy); end
      checks++; if (poe !== 1'b0) begin failures++; $display("FAIL turn_oe[%0d] got=%b exp=0", i, poe); end
      tick();
    end
    checks++; if ({rdy, busy} !== 2'b10) begin failures++; $display("FAIL turn_done ready/busy got=%b%b exp=10", rdy, busy); end
    tick();
    checks++; if ({poe, pout} !== 2'b11) begin failures++; $display("FAIL redrive oe/out got=%b%b exp=11", poe, pout); end
    valid = 0;
    tick();
  endtask
  task automatic test_turn_zero();
    valid = 1; oe = 1; data = 1;
    tick();
    checks++; if (poe0 !== 1'b1) begin failures++; $display("FAIL t0_drive_oe got=%b exp=1", poe0); end
    oe = 0;
    tick();
    checks++; if (poe0 !== 1'b0) begin failures++; $display("FAIL t0_release_oe got=%b exp=0", poe0); end
    checks++; if ({rdy0, busy0} !== 2'b10) begin failures++; $display("FAIL t0_nostall ready/busy got=%b%b exp=10", rdy0, busy0); end
    oe = 1;
    tick();
    checks++; if (poe0 !== 1'b1) begin failures++; $display("FAIL t0_redrive_oe got=%b exp=1", poe0); end
    valid = 0;
    tick(); tick(); tick();
  endtask
  task automatic test_reset_mid_turn();
    valid = 1; oe = 1; data = 1; attr = 16'h1234;
    tick();
    oe = 0;
    tick();
    valid = 0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midturn_enter busy got=%b exp=1", busy); end
    rst = 1;
    tick();
    rst = 0;
    checks++; if ({rdy, busy} !== 2'b10) begin failures++; $display("FAIL midturn_rst ready/busy got=%b%b exp=10", rdy, busy); end
    checks++; if ({poe, pout, pattr} !== 18'h0) begin failures++; $display("FAIL midturn_rst outs got=%b%b%h exp=000000", poe, pout, pattr); end
  endtask
  task automatic test_readback();
    logic exp_c;
`ifdef PAD_OUT_READBACK_EN
    exp_c = 1;
`else
    exp_c = 0;
`endif
    sense = 1;
    valid = 1; oe = 1; data = 1;
    tick();
    valid = 0; sense = 0;
    tick(); tick();
    checks++; if (conf !== exp_c) begin failures++; $display("FAIL readback_set got=%b exp=%b", conf, exp_c); end
    sense = 1;
    tick();
    checks++; if (conf !== exp_c) begin failures++; $display("FAIL readback_sticky got=%b exp=%b", conf, exp_c); end
    clr = 1;
    tick();
    clr = 0;
    checks++; if (conf !== 1'b0) begin failures++; $display("FAIL readback_clr got=%b exp=0", conf); end
    tick();
    checks++; if (conf !== 1'b0) begin failures++; $display("FAIL readback_stay got=%b exp=0", conf); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      valid = ($urandom_range(0, 3) != 0);
      oe = ($urandom_range(0, 2) != 0);
      data = 1'($urandom);
      attr = 16'($urandom);
      clr = 1'($urandom);
      tick();
      sense = m_out;
      checks++; if ({rdy, busy} !== {m_left == 0, m_left > 0}) begin failures++; $display("FAIL rnd_rb[%0d] got=%b%b exp=%b%b", i, rdy, busy, m_left == 0, m_left > 0); end
      checks++; if ({poe, pout, pattr} !== {m_oe, m_out, m_attr}) begin failures++; $display("FAIL rnd_pad[%0d] got=%b%b%h exp=%b%b%h", i, poe, pout, pattr, m_oe, m_out, m_attr); end
      checks++; if ({rdy0, busy0} !== {m_left0 == 0, m_left0 > 0}) begin failures++; $display("FAIL rnd0_rb[%0d] got=%b%b exp=%b%b", i, rdy0, busy0, m_left0 == 0, m_left0 > 0); end
      checks++; if ({poe0, pout0, pattr0} !== {m_oe0, m_out0, m_attr0}) begin failures++; $display("FAIL rnd0_pad[%0d] got=%b%b%h exp=%b%b%h", i, poe0, pout0, pattr0, m_oe0, m_out0, m_attr0); end
`ifndef PAD_OUT_READBACK_EN
      checks++; if ({conf, conf0} !== 2'b00) begin failures++; $display("FAIL rnd_conflict[%0d] got=%b%b exp=00", i, conf, conf0); end
`endif
    end
    rst = 0; valid = 0; clr = 0;
  endtask
  initial begin
    test_reset();
    test_drive_stream();
    test_back_to_back_release();
    test_turn_zero();
    test_reset_mid_turn();
    test_readback();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
